// File: rtl/psg_bus_write_port.sv
// rtl/psg_bus_write_port.sv - host bus write front-end for the SN76489-compatible PSG core
//
// Purpose: synchronises the asynchronous chip-style host bus (/WE, /CE) into
// the PSG clock domain, buffers host writes in a small FIFO and drains them to
// the control-register decoder one byte at a time, no closer together than
// WRITE_CYCLES clocks.
//
// Ports:
//   clk         PSG master clock
//   reset       asynchronous, active-high reset
//   bus_data    host data bus (bit 7 = latch/data flag, decoded downstream)
//   bus_we_n    host write enable, active low, asynchronous
//   bus_ce_n    host chip enable, active low, asynchronous
//   ready       high while the FIFO can accept a write
//   data_out    byte presented to the control-register decoder
//   data_valid  one-cycle strobe qualifying data_out
//   overflow    sticky: a write was dropped because the FIFO was full
//   fifo_level  number of buffered entries
module psg_bus_write_port #(
    parameter int SYNC_STAGES  = 2,
    parameter int WRITE_CYCLES = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    bus_data,
    input  logic                          bus_we_n,
    input  logic                          bus_ce_n,
    output logic                          ready,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WRITE_CYCLES);

    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(WRITE_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic                   sel_n;
    logic                   sel_s;
    logic                   sel_valid;
    logic                   strobe;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   full;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] warm_q, warm_d;
    logic                   sel_prev_q, sel_prev_d;
    logic                   armed_q, armed_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   ready_q, ready_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             mem_q [FIFO_DEPTH];

    assign sel_n = bus_we_n | bus_ce_n;
    assign sel_s = sync_q[SYNC_STAGES-1];
    // The synchroniser resets to 1, so its output is not a real bus sample
    // until the warm-up chain has filled; arming only on a real high keeps a
    // bus held low across reset release from looking like a falling edge.
    assign sel_valid = warm_q[SYNC_STAGES-1];
    assign strobe    = armed_q & sel_prev_q & ~sel_s;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], sel_n};
        warm_d     = {warm_q[SYNC_STAGES-2:0], 1'b1};
        sel_prev_d = sel_s;
        armed_d    = armed_q | (sel_valid & sel_s);

        full = (level_q == DEPTH_L);
        pop  = (state_q == IDLE) && (level_q != '0);
        // A full FIFO still accepts a push when the head is popped on the same edge.
        push = strobe && (!full || pop);
        drop = strobe && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        ready_d    = (level_d < DEPTH_L);
        overflow_d = overflow_q | drop;

        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_out_d   = mem_q[rd_ptr_q];
                    data_valid_d = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = BUSY;
                end
            end
            default: begin
                // Leaving as the count reaches 0 lets the next IDLE pop land
                // exactly WRITE_CYCLES clocks after the previous one.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '1;
            warm_q       <= '0;
            sel_prev_q   <= 1'b1;
            armed_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ready_q      <= 1'b1;
            overflow_q   <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            sync_q       <= sync_d;
            warm_q       <= warm_d;
            sel_prev_q   <= sel_prev_d;
            armed_q      <= armed_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ready_q      <= ready_d;
            overflow_q   <= overflow_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= bus_data;
            end
        end
    end

    assign ready      = ready_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_psg_bus_write_port.sv
// tb/tb_psg_bus_write_port.sv - self-checking bench for psg_bus_write_port
module tb_psg_bus_write_port;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus_data = 8'h00;
    logic       bus_we_n = 1'b1;
    logic       bus_ce_n = 1'b1;
    logic       ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overflow;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] vq[$];
    int         tq[$];
    logic       ready_low_seen = 1'b0;

    psg_bus_write_port dut (
        .clk        (clk),
        .reset      (reset),
        .bus_data   (bus_data),
        .bus_we_n   (bus_we_n),
        .bus_ce_n   (bus_ce_n),
        .ready      (ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            vq.push_back(data_out);
            tq.push_back(cyc);
        end
        if (!ready) ready_low_seen = 1'b1;
    end

    // Called at a negedge; leaves the bus deasserted after low_cycles clocks.
    task automatic bus_write(input logic [7:0] d, input int low_cycles);
        bus_data = d;
        bus_we_n = 1'b0;
        bus_ce_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        bus_we_n = 1'b1;
        bus_ce_n = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single;
        int c;
        vq.delete(); tq.delete();
        c = cyc;
        bus_data = 8'h9F; bus_we_n = 1'b0; bus_ce_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_we_n = 1'b1; bus_ce_n = 1'b1;
        @(negedge clk);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_push: got %0d want 1", fifo_level); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", ready); end
        @(negedge clk);
        checks++; if (data_valid !== 1'b1 || data_out !== 8'h9F) begin errors++; $display("FAIL single_strobe: got valid=%b data=%h want valid=1 data=9f", data_valid, data_out); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_pop: got %0d want 0", fifo_level); end
        repeat (40) @(negedge clk);
        checks++; if (vq.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", vq.size()); end
        else begin
            checks++; if (tq[0] != c + 4) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", tq[0], c + 4); end
            checks++; if (data_out !== 8'h9F) begin errors++; $display("FAIL single_hold: got %h want 9f", data_out); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [3];
        exp[0] = 8'h80; exp[1] = 8'h05; exp[2] = 8'h90;
        vq.delete(); tq.delete();
        for (int i = 0; i < 3; i++) begin
            bus_write(exp[i], 2);
            repeat (2) @(negedge clk);
        end
        repeat (110) @(negedge clk);
        checks++;
        if (vq.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d want 3", vq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (vq[i] !== exp[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, vq[i], exp[i]); end
            end
            checks++; if (tq[1] - tq[0] != 32) begin errors++; $display("FAIL b2b_gap01: got %0d want 32", tq[1] - tq[0]); end
            checks++; if (tq[2] - tq[1] != 32) begin errors++; $display("FAIL b2b_gap12: got %0d want 32", tq[2] - tq[1]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        vq.delete(); tq.delete();
        ready_low_seen = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i);
            bus_write(b, 2);
            repeat (2) @(negedge clk);
        end
        checks++; if (ready_low_seen !== 1'b1) begin errors++; $display("FAIL ovf_ready_drop: got %b want 1", ready_low_seen); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        repeat (200) @(negedge clk);
        checks++;
        if (vq.size() != 5) begin
            errors++; $display("FAIL ovf_count: got %0d want 5", vq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                b = 8'(i + 1);
                if (vq[i] !== b) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, vq[i], b); end
            end
        end
        checks++; if (overflow !== 1'b1 || ready !== 1'b1 || fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_final: got ovf=%b ready=%b level=%0d want 1 1 0", overflow, ready, fifo_level); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'h11 * 8'(i + 1);
            bus_write(b, 2);
            repeat (2) @(negedge clk);
        end
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level_before: got %0d want 3", fifo_level); end
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b1 || data_out !== 8'h00 || data_valid !== 1'b0 || overflow !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got ready=%b data=%h valid=%b ovf=%b level=%0d want 1 00 0 0 0", ready, data_out, data_valid, overflow, fifo_level);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vq.delete(); tq.delete();
        repeat (100) @(negedge clk);
        checks++; if (vq.size() != 0) begin errors++; $display("FAIL mid_no_output: got %0d pulses want 0", vq.size()); end
    endtask

    task automatic test_held_low;
        reset = 1'b1;
        bus_data = 8'h5A; bus_we_n = 1'b0; bus_ce_n = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vq.delete(); tq.delete();
        repeat (20) @(negedge clk);
        checks++; if (vq.size() != 0 || fifo_level !== 3'd0) begin errors++; $display("FAIL held_low_no_write: got pulses=%0d level=%0d want 0 0", vq.size(), fifo_level); end
        bus_we_n = 1'b1; bus_ce_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_write(8'hA5, 2);
        repeat (40) @(negedge clk);
        checks++;
        if (vq.size() != 1) begin errors++; $display("FAIL held_low_rewrite_count: got %0d want 1", vq.size()); end
        else if (vq[0] !== 8'hA5) begin errors++; $display("FAIL held_low_rewrite_data: got %h want a5", vq[0]); end
    endtask

    task automatic test_long_low;
        vq.delete(); tq.delete();
        bus_write(8'hE4, 50);
        repeat (40) @(negedge clk);
        checks++;
        if (vq.size() != 1) begin errors++; $display("FAIL long_low_count: got %0d want 1", vq.size()); end
        else if (vq[0] !== 8'hE4) begin errors++; $display("FAIL long_low_data: got %h want e4", vq[0]); end
        checks++; if (overflow !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL long_low_state: got ovf=%b level=%0d want 0 0", overflow, fifo_level); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_reset_mid;
        test_held_low;
        test_long_low;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
